// File: rtl/edge_evt_pkg.sv
// Shared types and helpers for the edge event arbiter: FSM state encoding
// and the round-robin picker used by the top-level scheduler.
package edge_evt_pkg;

    localparam int MAX_CH  = 16;
    localparam int MAX_IDW = 4;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PRESENT = 1'b1
    } state_e;

    // Returns {found, id}. Search starts one past 'last' and wraps at n,
    // so the most recently granted channel gets the lowest priority.
    function automatic logic [MAX_IDW:0] rr_pick(
        input logic [MAX_CH-1:0]  pend,
        input logic [MAX_IDW-1:0] last,
        input int                 n
    );
        logic               found;
        logic [MAX_IDW-1:0] id;
        int                 idx;
        found = 1'b0;
        id    = '0;
        for (int k = 1; k <= MAX_CH; k++) begin
            idx = int'(last) + k;
            if (idx >= n) idx = idx - n;
            if (k <= n && !found && pend[idx[MAX_IDW-1:0]]) begin
                found = 1'b1;
                id    = idx[MAX_IDW-1:0];
            end
        end
        return {found, id};
    endfunction

endpackage

// File: rtl/edge_sync_channel.sv
// One input channel: synchronizer chain, history flop, rising-edge detect,
// sticky pending flag and sticky overflow flag.
module edge_sync_channel #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic in_async_i,
    input  logic ch_enable_i,
    input  logic grant_i,
    input  logic ovf_clr_i,
    output logic pending_o,
    output logic ovf_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;
    logic                   pending_q, pending_d;
    logic                   ovf_q, ovf_d;
    logic                   sync_last;
    logic                   edge_det;

    assign sync_last = sync_q[SYNC_STAGES-1];
    assign edge_det  = sync_last & ~hist_q & ch_enable_i;

    always_comb begin
        pending_d = pending_q;
        if (!ch_enable_i)  pending_d = 1'b0;
        else if (edge_det) pending_d = 1'b1;
        else if (grant_i)  pending_d = 1'b0;
    end

    // A second edge while the first is still waiting means one was merged.
    always_comb begin
        ovf_d = ovf_q;
        if (edge_det && pending_q && !grant_i) ovf_d = 1'b1;
        else if (ovf_clr_i)                    ovf_d = 1'b0;
    end

    // Sync and history reset high so a line already high at reset is not an edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q    <= '1;
            hist_q    <= 1'b1;
            pending_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], in_async_i};
            hist_q    <= sync_last;
            pending_q <= pending_d;
            ovf_q     <= ovf_d;
        end
    end

    assign pending_o = pending_q;
    assign ovf_o     = ovf_q;

endmodule

// File: rtl/edge_event_arbiter.sv
// Collects rising edges from N_CH asynchronous inputs and hands them one at a
// time to a valid/ready consumer, scheduled round-robin.
module edge_event_arbiter
    import edge_evt_pkg::*;
#(
    parameter  int N_CH        = 4,
    parameter  int SYNC_STAGES = 2,
    localparam int ID_W        = $clog2(N_CH)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_CH-1:0] in_async,
    input  logic [N_CH-1:0] ch_enable,
    output logic            evt_valid,
    output logic [ID_W-1:0] evt_id,
    input  logic            evt_ready,
    output logic [N_CH-1:0] pending,
    output logic [N_CH-1:0] ovf,
    input  logic [N_CH-1:0] ovf_clr
);

    state_e             state_q;
    logic               evt_valid_q;
    logic [ID_W-1:0]    evt_id_q;
    logic [ID_W-1:0]    last_q;

    logic [N_CH-1:0]    pend_w;
    logic [N_CH-1:0]    grant;
    logic [MAX_CH-1:0]  pend16;
    logic [MAX_IDW-1:0] last4;
    logic [MAX_IDW:0]   pick;
    logic               pick_found;
    logic [MAX_IDW-1:0] pick_id;
    logic               can_grant;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        edge_sync_channel #(
            .SYNC_STAGES (SYNC_STAGES)
        ) u_ch (
            .clk         (clk),
            .reset       (reset),
            .in_async_i  (in_async[i]),
            .ch_enable_i (ch_enable[i]),
            .grant_i     (grant[i]),
            .ovf_clr_i   (ovf_clr[i]),
            .pending_o   (pend_w[i]),
            .ovf_o       (ovf[i])
        );
    end

    // Mask with enable so a flag that is being cleared this cycle is never granted.
    always_comb begin
        pend16             = '0;
        pend16[N_CH-1:0]   = pend_w & ch_enable;
        last4              = '0;
        last4[ID_W-1:0]    = last_q;
    end

    assign pick       = rr_pick(pend16, last4, N_CH);
    assign pick_found = pick[MAX_IDW];
    assign pick_id    = pick[MAX_IDW-1:0];
    assign can_grant  = (state_q == ST_IDLE) || evt_ready;

    always_comb begin
        grant = '0;
        for (int i = 0; i < N_CH; i++) begin
            grant[i] = can_grant && pick_found && (pick_id == MAX_IDW'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            evt_valid_q <= 1'b0;
            evt_id_q    <= '0;
            last_q      <= ID_W'(N_CH - 1);
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pick_found) begin
                        evt_valid_q <= 1'b1;
                        evt_id_q    <= pick_id[ID_W-1:0];
                        last_q      <= pick_id[ID_W-1:0];
                        state_q     <= ST_PRESENT;
                    end
                end
                ST_PRESENT: begin
                    // Accepted event is replaced in the same cycle when another is waiting.
                    if (evt_ready) begin
                        if (pick_found) begin
                            evt_id_q <= pick_id[ID_W-1:0];
                            last_q   <= pick_id[ID_W-1:0];
                        end else begin
                            evt_valid_q <= 1'b0;
                            state_q     <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    evt_valid_q <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign evt_valid = evt_valid_q;
    assign evt_id    = evt_id_q;
    assign pending   = pend_w;

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Directed bench for edge_event_arbiter: latency, reset-high inputs,
// round-robin order, overflow, disable and reset while presenting.
module tb_edge_event_arbiter;

    localparam int N_CH = 4;
    localparam int ID_W = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic [N_CH-1:0] in_async;
    logic [N_CH-1:0] ch_enable;
    logic            evt_valid;
    logic [ID_W-1:0] evt_id;
    logic            evt_ready;
    logic [N_CH-1:0] pending;
    logic [N_CH-1:0] ovf;
    logic [N_CH-1:0] ovf_clr;

    int n_cmp = 0;
    int n_bad = 0;
    int got_q[$];

    always #5 clk = ~clk;

    edge_event_arbiter #(.N_CH(N_CH), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_async  (in_async),
        .ch_enable (ch_enable),
        .evt_valid (evt_valid),
        .evt_id    (evt_id),
        .evt_ready (evt_ready),
        .pending   (pending),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Records every accepted event over a bounded window.
    task automatic collect(input int cycles);
        got_q.delete();
        for (int i = 0; i < cycles; i++) begin
            if (evt_valid && evt_ready) got_q.push_back(int'(evt_id));
            @(negedge clk);
        end
    endtask

    task automatic chk_seq(input string tag, input int n, input int e0, input int e1, input int e2);
        int e;
        chk({tag, "_count"}, got_q.size(), n);
        for (int i = 0; i < n; i++) begin
            e = (i == 0) ? e0 : (i == 1) ? e1 : e2;
            chk({tag, "_id"}, (i < got_q.size()) ? got_q[i] : 32'hFFFF, e);
        end
    endtask

    initial begin
        reset     = 1'b1;
        in_async  = '0;
        ch_enable = '1;
        evt_ready = 1'b1;
        ovf_clr   = '0;
        tick(3);
        chk("rst_valid", evt_valid, 0);
        chk("rst_id", evt_id, 0);
        chk("rst_pending", pending, 0);
        chk("rst_ovf", ovf, 0);
        reset = 1'b0;
        tick(2);

        // Single event on channel 2: pending after edge 2, valid after edge 3 for one cycle.
        in_async[2] = 1'b1;
        for (int k = 0; k <= 4; k++) begin
            @(negedge clk);
            if (k == 1) chk("single_pend_e1", pending, 4'b0000);
            if (k == 2) begin
                chk("single_pend_e2", pending, 4'b0100);
                chk("single_valid_e2", evt_valid, 0);
            end
            if (k == 3) begin
                chk("single_valid_e3", evt_valid, 1);
                chk("single_id_e3", evt_id, 2);
            end
            if (k == 4) chk("single_valid_e4", evt_valid, 0);
        end
        in_async[2] = 1'b0;
        tick(4);

        // Input held high through reset produces no event.
        reset = 1'b1;
        in_async[1] = 1'b1;
        tick(3);
        reset = 1'b0;
        tick(6);
        chk("hirst_pending", pending, 0);
        chk("hirst_valid", evt_valid, 0);
        in_async[1] = 1'b0;
        tick(4);

        // Round-robin: 0,1,3 together, consumer stalled then released.
        evt_ready = 1'b0;
        in_async  = 4'b1011;
        tick(10);
        chk("rr_stall_valid", evt_valid, 1);
        chk("rr_stall_id", evt_id, 0);
        chk("rr_stall_pend", pending, 4'b1010);
        evt_ready = 1'b1;
        collect(6);
        chk_seq("rr_013", 3, 0, 1, 3);
        in_async = '0;
        tick(4);
        // last_grant is 3, so search begins at 0.
        in_async = 4'b1001;
        collect(8);
        chk_seq("rr_03", 2, 0, 3, 0);
        in_async = '0;
        tick(4);
        // Make last_grant 1, then 3 should precede 0.
        in_async[1] = 1'b1;
        collect(8);
        chk_seq("rr_1", 1, 1, 0, 0);
        in_async = '0;
        tick(4);
        in_async = 4'b1001;
        collect(8);
        chk_seq("rr_30", 2, 3, 0, 0);
        in_async = '0;
        tick(4);

        // Overflow: channel 0 presented and stalled, channel 1 pulsed twice.
        evt_ready = 1'b0;
        in_async[0] = 1'b1;
        tick(5);
        chk("ovf_pres_id", evt_id, 0);
        in_async[0] = 1'b0;
        for (int p = 0; p < 2; p++) begin
            in_async[1] = 1'b1;
            tick(3);
            in_async[1] = 1'b0;
            tick(3);
        end
        chk("ovf_flag", ovf, 4'b0010);
        chk("ovf_pend", pending, 4'b0010);
        chk("ovf_hold_valid", evt_valid, 1);
        chk("ovf_hold_id", evt_id, 0);
        ovf_clr[1] = 1'b1;
        tick(1);
        ovf_clr[1] = 1'b0;
        chk("ovf_clr", ovf, 0);
        evt_ready = 1'b1;
        collect(6);
        chk_seq("ovf_drain", 2, 0, 1, 0);
        chk("ovf_drain_pend", pending, 0);

        // Disable: pending[3] dropped, edges ignored while disabled.
        evt_ready = 1'b0;
        in_async[0] = 1'b1;
        tick(5);
        in_async[3] = 1'b1;
        tick(4);
        chk("dis_pend_set", pending, 4'b1000);
        ch_enable[3] = 1'b0;
        tick(1);
        chk("dis_pend_clr", pending, 0);
        in_async[3] = 1'b0;
        tick(3);
        in_async[3] = 1'b1;
        tick(4);
        chk("dis_ignored", pending, 0);
        ch_enable[0] = 1'b0;
        tick(1);
        chk("dis_pres_valid", evt_valid, 1);
        chk("dis_pres_id", evt_id, 0);
        ch_enable[0] = 1'b1;
        in_async = '0;
        tick(3);
        ch_enable[3] = 1'b1;
        evt_ready = 1'b1;
        collect(6);
        chk_seq("dis_drain", 1, 0, 0, 0);
        in_async[3] = 1'b1;
        collect(8);
        chk_seq("dis_reen", 1, 3, 0, 0);
        in_async = '0;
        tick(4);

        // Reset while presenting, with a pending event and an overflow flag.
        evt_ready = 1'b0;
        in_async  = 4'b0011;
        tick(5);
        in_async[1] = 1'b0;
        tick(3);
        in_async[1] = 1'b1;
        tick(4);
        chk("rp_valid_pre", evt_valid, 1);
        chk("rp_ovf_pre", ovf, 4'b0010);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        chk("rp_valid", evt_valid, 0);
        chk("rp_id", evt_id, 0);
        chk("rp_pend", pending, 0);
        chk("rp_ovf", ovf, 0);
        tick(5);
        chk("rp_quiet", evt_valid, 0);
        in_async = '0;
        tick(4);
        evt_ready = 1'b1;
        in_async[2] = 1'b1;
        collect(8);
        chk_seq("rp_after", 1, 2, 0, 0);
        in_async = '0;
        tick(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/edge_event_arbiter.md
# edge_event_arbiter

Collects rising edges from `N_CH` asynchronous inputs (push-buttons, external strobes) and delivers them one at a time to a single consumer through a valid/ready event port. Each channel has its own synchronizer, edge detector, sticky pending flag and overflow flag. A round-robin arbiter schedules the pending channels. The block sits between the board-level inputs and the control FSM or bus interface that services them, so that no edge is lost while the consumer is busy.

## Interface
- `N_CH`, 4: number of input channels; legal range 2..16.
- `SYNC_STAGES`, 2: synchronizer flops per channel; legal range 2..4.
- `ID_W`, `$clog2(N_CH)`: width of the event ID; derived, never overridden.

- `clk`  in  1  single system clock; all logic is on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_async`  in  N_CH  raw asynchronous inputs.
- `ch_enable`  in  N_CH  per-channel enable, synchronous to `clk`.
- `evt_valid`  out  1  an event is presented.
- `evt_id`  out  ID_W  channel number of the presented event.
- `evt_ready`  in  1  consumer accepts the event.
- `pending`  out  N_CH  current pending flags (status).
- `ovf`  out  N_CH  sticky overflow flags (status).
- `ovf_clr`  in  N_CH  write-one-to-clear pulses for `ovf`.

## Operation
- **Synchronizer:** each channel runs `SYNC_STAGES` flops, then one history flop.
  - All sync and history flops reset to 1, so an input already high at reset produces no event.
- **Edge pulse:** `edge[i] = sync_last[i] & ~hist[i] & ch_enable[i]`, one cycle wide.
- **Pending flag update (per channel):**
  - Set when `edge[i]` is 1.
  - Cleared when channel i is granted.
  - Set wins over clear in the same cycle; that edge is a new event.
  - Cleared whenever `ch_enable[i]` is 0.
- **Overflow flag (per channel):**
  - Set when `edge[i]` is 1 while `pending[i]` is already 1 and channel i is not granted that cycle.
  - Cleared by `ovf_clr[i]`; set wins if both occur in the same cycle.
- **FSM states:** IDLE and PRESENT.
  - IDLE: if any `pending` bit is set, grant the winner, load `evt_id`, clear that pending bit, go to PRESENT. Otherwise stay in IDLE.
  - PRESENT, `evt_ready` low: hold `evt_id` and `evt_valid`.
  - PRESENT, `evt_ready` high, another channel pending: grant it in the same cycle (back-to-back) and stay in PRESENT.
  - PRESENT, `evt_ready` high, nothing pending: go to IDLE.
- **Round-robin:**
  - Search starts at `last_grant+1` mod `N_CH`.
  - `last_grant` resets to `N_CH-1`, so channel 0 has first priority after reset.
- **Disable during PRESENT:** deasserting `ch_enable` for the channel currently presented does not withdraw the event.
- **Reset mid-operation:** drops the presented event and clears all pending and overflow flags.

## Timing
- **Reset values:** `evt_valid`=0, `evt_id`=0, `pending`=0, `ovf`=0, FSM=IDLE.
- **Latency:**
  - Call edge 0 the first `clk` edge that samples `in_async[i]` high.
  - `pending[i]` rises after edge `SYNC_STAGES`.
  - `evt_valid` rises after edge `SYNC_STAGES+1` if the FSM is IDLE and channel i wins arbitration.
- **Handshake:** an event transfers on any cycle with `evt_valid && evt_ready`.
  - `evt_id` is stable while `evt_valid` is high and `evt_ready` is low.
- **Throughput:** one event per cycle under continuous `evt_ready`.
- **Pulse width:** inputs must stay high or low for at least 2 `clk` cycles; shorter pulses may be missed.
- **Registered outputs:** all outputs come directly from flops; no combinational path from `evt_ready` to any output.

## Structure
- **Shared package** (e.g. `edge_evt_pkg`):
  - FSM state enum (IDLE, PRESENT).
  - Function `rr_pick(pending, last)` returning `{found, id}`.
- **Sub-module `edge_sync_channel`:**
  - Holds one channel's sync chain, history flop, pending flag and overflow flag.
  - Instanced `N_CH` times with a generate loop.
- **Top level:** arbiter and FSM only.

## Test plan
- **Single event:** reset, then raise `in_async[2]` with `evt_ready`=1. `evt_valid` high for exactly one cycle, after edge 3, with `evt_id`=2.
- **High at reset:** hold `in_async[1]` high through reset and release reset. No event; `pending`=0.
- **Round-robin:** raise channels 0, 1 and 3 together with `evt_ready` held 0 for 10 cycles, then held 1. Events issue back-to-back as IDs 0, 1, 3. A repeat on channels 0 and 3 then issues 3 before 0 only if `last_grant`=1; check the order against the `last_grant` rule.
- **Overflow:** with `evt_ready`=0 and channel 0 presented, pulse channel 1 twice (3-cycle pulses). `ovf[1]`=1 and a single channel-1 event remains pending. `ovf_clr[1]` pulse then reads `ovf[1]`=0.
- **Disable:** set `pending[3]`=1, then drop `ch_enable[3]`. `pending[3]`=0 next cycle, and edges on channel 3 are ignored until re-enabled.
- **Reset while presenting:** assert `reset` while `evt_valid`=1. Next cycle `evt_valid`=0, all flags are 0, and the FSM is IDLE.
